// File: rtl/ps2_key_decoder_if.sv
// Byte stream from the PS/2 receiver and decoded key events/levels for the VGA side.
interface ps2_key_decoder_if;
    logic [7:0] rx_data;
    logic       read_data;
    logic       rx_err;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_event;
    logic       key_held;
    logic       dir_left;
    logic       dir_right;
    logic       dir_up;
    logic       dir_down;

    modport master (
        output rx_data, read_data, rx_err,
        input  key_code, key_ext, key_event, key_held,
        input  dir_left, dir_right, dir_up, dir_down
    );

    modport slave (
        input  rx_data, read_data, rx_err,
        output key_code, key_ext, key_event, key_held,
        output dir_left, dir_right, dir_up, dir_down
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// Parses PS/2 set-2 make/break/extended sequences into key events, a latched
// scan code, and held-key direction levels.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_WIDTH      = 21
) (
    input  logic               clk,
    input  logic               reset,
    ps2_key_decoder_if.slave   bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXT     = 2'd1;
    localparam logic [1:0] BRK     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;

    logic [1:0]           state;
    logic [1:0]           next_state;
    logic [CNT_WIDTH-1:0] timeout_cnt;
    logic [7:0]           key_code;
    logic                 key_ext;
    logic                 key_event;
    logic                 key_held;
    logic [7:0]           dir_src;
    logic                 do_make;
    logic                 do_break;
    logic                 ext_bit;
    logic                 code_match;
    logic [7:0]           byte_mask;

    // One bit per direction source; the letter key and the arrow key are
    // tracked separately so releasing one does not drop a level the other holds.
    function automatic logic [7:0] dir_mask(input logic [7:0] code, input logic ext);
        logic [7:0] m;
        m = 8'h00;
        case ({ext, code})
            9'h01C: m[0] = 1'b1;
            9'h16B: m[1] = 1'b1;
            9'h023: m[2] = 1'b1;
            9'h174: m[3] = 1'b1;
            9'h01D: m[4] = 1'b1;
            9'h175: m[5] = 1'b1;
            9'h01B: m[6] = 1'b1;
            9'h172: m[7] = 1'b1;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    always_comb begin
        next_state = state;
        do_make    = 1'b0;
        do_break   = 1'b0;
        ext_bit    = 1'b0;
        if (bus.read_data) begin
            case (state)
                IDLE: begin
                    case (bus.rx_data)
                        8'hF0: next_state = BRK;
                        8'hE0: next_state = EXT;
                        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: next_state = IDLE;
                        default: do_make = 1'b1;
                    endcase
                end
                EXT: begin
                    ext_bit = 1'b1;
                    case (bus.rx_data)
                        8'hF0: next_state = EXT_BRK;
                        8'hE0: next_state = EXT;
                        8'h12, 8'h59: next_state = IDLE;
                        default: begin
                            do_make    = 1'b1;
                            next_state = IDLE;
                        end
                    endcase
                end
                BRK: begin
                    do_break   = 1'b1;
                    next_state = IDLE;
                end
                default: begin
                    ext_bit    = 1'b1;
                    do_break   = 1'b1;
                    next_state = IDLE;
                end
            endcase
        end
    end

    assign code_match = (bus.rx_data == key_code) && (ext_bit == key_ext);
    assign byte_mask  = dir_mask(bus.rx_data, ext_bit);

    // An error strobe outranks a byte in the same cycle, and a byte outranks
    // timeout expiry; a make that repeats the held key changes nothing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            timeout_cnt <= '0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_event   <= 1'b0;
            key_held    <= 1'b0;
            dir_src     <= 8'h00;
        end else begin
            key_event <= 1'b0;
            if (bus.rx_err) begin
                state       <= IDLE;
                timeout_cnt <= '0;
            end else if (bus.read_data) begin
                state       <= next_state;
                timeout_cnt <= '0;
                if (do_make) begin
                    dir_src <= dir_src | byte_mask;
                    if (!(key_held && code_match)) begin
                        key_code  <= bus.rx_data;
                        key_ext   <= ext_bit;
                        key_held  <= 1'b1;
                        key_event <= 1'b1;
                    end
                end
                if (do_break) begin
                    dir_src <= dir_src & ~byte_mask;
                    if (code_match) begin
                        key_held <= 1'b0;
                    end
                end
            end else if (state != IDLE) begin
                if (timeout_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    state       <= IDLE;
                    timeout_cnt <= '0;
                end else begin
                    timeout_cnt <= timeout_cnt + CNT_WIDTH'(1);
                end
            end else begin
                timeout_cnt <= '0;
            end
        end
    end

    assign bus.key_code  = key_code;
    assign bus.key_ext   = key_ext;
    assign bus.key_event = key_event;
    assign bus.key_held  = key_held;
    assign bus.dir_left  = dir_src[0] | dir_src[1];
    assign bus.dir_right = dir_src[2] | dir_src[3];
    assign bus.dir_up    = dir_src[4] | dir_src[5];
    assign bus.dir_down  = dir_src[6] | dir_src[7];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with a shortened timeout so expiry can be exercised.
module tb_ps2_key_decoder;

    localparam int TMO = 40;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   pulses;

    ps2_key_decoder_if bus();

    ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one strobe for one edge; outputs are sampled 1 ns after that edge.
    task automatic applyStimulus(input logic [7:0] b, input logic err);
        bus.rx_data   = b;
        bus.read_data = 1'b1;
        bus.rx_err    = err;
        @(posedge clk);
        #1;
        bus.read_data = 1'b0;
        bus.rx_err    = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] dirs();
        return {bus.dir_left, bus.dir_right, bus.dir_up, bus.dir_down};
    endfunction

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        bus.rx_data   = 8'h00;
        bus.read_data = 1'b0;
        bus.rx_err    = 1'b0;
        idleCycles(3);
        reset = 1'b1;

        checkOutput("rst_code", bus.key_code, 8'h00);
        checkOutput("rst_ext", bus.key_ext, 0);
        checkOutput("rst_event", bus.key_event, 0);
        checkOutput("rst_held", bus.key_held, 0);
        checkOutput("rst_dirs", dirs(), 4'b0000);

        // A make, then break
        applyStimulus(8'h1C, 0);
        checkOutput("a_event", bus.key_event, 1);
        checkOutput("a_code", bus.key_code, 8'h1C);
        checkOutput("a_ext", bus.key_ext, 0);
        checkOutput("a_held", bus.key_held, 1);
        checkOutput("a_dirs", dirs(), 4'b1000);
        idleCycles(1);
        checkOutput("a_pulse_end", bus.key_event, 0);
        applyStimulus(8'hF0, 0);
        checkOutput("f0_no_event", bus.key_event, 0);
        applyStimulus(8'h1C, 0);
        checkOutput("a_rel_held", bus.key_held, 0);
        checkOutput("a_rel_dirs", dirs(), 4'b0000);
        checkOutput("a_rel_code", bus.key_code, 8'h1C);

        // Typematic E0 75 back-to-back
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'hE0, 0);
            pulses += int'(bus.key_event);
            applyStimulus(8'h75, 0);
            pulses += int'(bus.key_event);
        end
        checkOutput("up_pulses", pulses, 1);
        checkOutput("up_dirs", dirs(), 4'b0010);
        checkOutput("up_ext", bus.key_ext, 1);
        checkOutput("up_code", bus.key_code, 8'h75);
        applyStimulus(8'hE0, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h75, 0);
        checkOutput("up_rel_dirs", dirs(), 4'b0000);
        checkOutput("up_rel_held", bus.key_held, 0);

        // Two left sources
        applyStimulus(8'h1C, 0);
        applyStimulus(8'hE0, 0);
        applyStimulus(8'h6B, 0);
        checkOutput("l2_dirs", dirs(), 4'b1000);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h1C, 0);
        checkOutput("l2_a_rel_dirs", dirs(), 4'b1000);
        checkOutput("l2_a_rel_held", bus.key_held, 1);
        applyStimulus(8'hE0, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h6B, 0);
        checkOutput("l2_all_rel_dirs", dirs(), 4'b0000);
        checkOutput("l2_all_rel_held", bus.key_held, 0);

        // Byte arriving on the expiry cycle is still parsed as extended
        applyStimulus(8'hE0, 0);
        idleCycles(TMO - 1);
        applyStimulus(8'h74, 0);
        checkOutput("edge_event", bus.key_event, 1);
        checkOutput("edge_ext", bus.key_ext, 1);
        checkOutput("edge_dirs", dirs(), 4'b0100);
        applyStimulus(8'hE0, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h74, 0);
        checkOutput("edge_rel_dirs", dirs(), 4'b0000);

        // One cycle later the parser has timed out
        applyStimulus(8'hE0, 0);
        idleCycles(TMO);
        applyStimulus(8'h74, 0);
        checkOutput("tmo_event", bus.key_event, 1);
        checkOutput("tmo_code", bus.key_code, 8'h74);
        checkOutput("tmo_ext", bus.key_ext, 0);
        checkOutput("tmo_dirs", dirs(), 4'b0000);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h74, 0);
        checkOutput("tmo_rel_held", bus.key_held, 0);

        // Error strobe aborts E0 F0 and discards its own byte
        applyStimulus(8'hE0, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h75, 1);
        checkOutput("err_no_event", bus.key_event, 0);
        applyStimulus(8'h75, 0);
        checkOutput("err_event", bus.key_event, 1);
        checkOutput("err_code", bus.key_code, 8'h75);
        checkOutput("err_ext", bus.key_ext, 0);
        checkOutput("err_dirs", dirs(), 4'b0000);

        // Reset mid-sequence
        applyStimulus(8'hE0, 0);
        applyStimulus(8'hF0, 0);
        reset = 1'b0;
        idleCycles(1);
        reset = 1'b1;
        checkOutput("mrst_code", bus.key_code, 8'h00);
        checkOutput("mrst_held", bus.key_held, 0);
        checkOutput("mrst_ext", bus.key_ext, 0);
        applyStimulus(8'h72, 0);
        checkOutput("mrst_event", bus.key_event, 1);
        checkOutput("mrst_make_code", bus.key_code, 8'h72);
        checkOutput("mrst_make_ext", bus.key_ext, 0);
        checkOutput("mrst_dirs", dirs(), 4'b0000);
        applyStimulus(8'hAA, 0);
        checkOutput("aa_no_event", bus.key_event, 0);
        applyStimulus(8'hFA, 0);
        checkOutput("fa_no_event", bus.key_event, 0);
        checkOutput("fa_code", bus.key_code, 8'h72);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
